// File: rtl/vga_mem_arbiter_pkg.sv
// vga_mem_arbiter_pkg: shared widths, arbiter state encoding, frame base default
// and the frame fetch-pointer advance helper.
package vga_mem_arbiter_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] VGA_BASE_DEF = 32'h8040_0000;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_VGA  = 2'd2
  } arb_state_e;

  // Next frame word address; wraps to base after the last word.
  function automatic logic [REG_W-1:0] next_ptr(
    input logic [REG_W-1:0] ptr,
    input logic [REG_W-1:0] base,
    input logic [REG_W-1:0] last
  );
    return (ptr == last) ? base : ptr + 32'd4;
  endfunction

endpackage

// File: rtl/vga_mem_arbiter_if.sv
// vga_mem_arbiter_if: CPU MEM-stage port, VGA FIFO port and RAM data port.
// slave = arbiter side; master = MEM/VGA/RAM side.
interface vga_mem_arbiter_if;
  import vga_mem_arbiter_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [REG_W-1:0]  cpu_addr;
  logic [3:0]        cpu_sel;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              stallreq;

  logic              vga_enable;
  logic              vga_frame_start;
  logic              vga_pop;
  logic [DATA_W-1:0] vga_data;
  logic              vga_empty;
  logic              vga_underflow;

  logic              ram_ce;
  logic              ram_we;
  logic [REG_W-1:0]  ram_addr;
  logic [3:0]        ram_sel;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_sel, cpu_wdata,
    output cpu_rdata, cpu_ack, stallreq,
    input  vga_enable, vga_frame_start, vga_pop,
    output vga_data, vga_empty, vga_underflow,
    output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_sel, cpu_wdata,
    input  cpu_rdata, cpu_ack, stallreq,
    output vga_enable, vga_frame_start, vga_pop,
    input  vga_data, vga_empty, vga_underflow,
    input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/vga_word_fifo.sv
// vga_word_fifo: sync word FIFO with flush; head reads 0 when empty.
// Ports: clk, rst, push_i/wdata_i, pop_i, flush_i, rdata_o, count_o, empty_o, full_o.
module vga_word_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [31:0]              wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [31:0]              rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = empty_o ? 32'h0 : mem_q[rd_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares the RAM port between CPU MEM and VGA prefetch FIFO.
// Ports: clk, rst, bus (slave: cpu_*, vga_*, ram_*); VGA_ARB_STATS_EN adds stat_*.
module vga_mem_arbiter
  import vga_mem_arbiter_pkg::*;
#(
  parameter int unsigned      ACCESS_CYCLES = 2,
  parameter int unsigned      FIFO_DEPTH    = 8,
  parameter int unsigned      LOW_WATER     = 2,
  parameter logic [REG_W-1:0] VGA_BASE      = VGA_BASE_DEF,
  parameter int unsigned      FRAME_WORDS   = 120000
) (
  input  logic             clk,
  input  logic             rst,
  vga_mem_arbiter_if.slave bus
`ifdef VGA_ARB_STATS_EN
  ,
  output logic [31:0]      stat_stall_cycles,
  output logic [15:0]      stat_underflows
`endif
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LOW_C = CW'(LOW_WATER);
  localparam logic [REG_W-1:0] LAST_ADDR =
    VGA_BASE + 32'(4 * (FRAME_WORDS - 1));

  arb_state_e       state_q;
  logic [3:0]       acc_cnt_q;
  logic             ram_ce_q;
  logic             ram_we_q;
  logic [31:0]      ram_addr_q;
  logic [3:0]       ram_sel_q;
  logic [31:0]      ram_wdata_q;
  logic             cpu_ack_q;
  logic [31:0]      cpu_rdata_q;
  logic [31:0]      ptr_q;
  logic             discard_q;
  logic             underflow_q;

  logic [CW-1:0]    fifo_cnt;
  logic [31:0]      fifo_rdata;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CW:0]      occ;
  logic             flush;
  logic             last;
  logic             push;
  logic             pop_empty;
  logic             vga_need;
  logic             cpu_go;
  logic             grant_vga;
  logic             grant_cpu;

  // Disabled prefetcher keeps the FIFO flushed and the pointer at base.
  assign flush = bus.vga_frame_start | ~bus.vga_enable;

  assign occ = {1'b0, fifo_cnt} + (CW+1)'(state_q == ARB_VGA);
  assign vga_need = ~flush & ~fifo_full & (occ < {1'b0, DEPTH_C});

  // Ack cycle is IDLE with cpu_req still high; don't restart it.
  assign cpu_go = bus.cpu_req & ~cpu_ack_q;

  assign grant_vga = vga_need & ((fifo_cnt <= LOW_C) | ~cpu_go);
  assign grant_cpu = cpu_go & ~grant_vga;

  assign last = (state_q != ARB_IDLE) && (acc_cnt_q == LAST_CNT);
  assign push = last & (state_q == ARB_VGA) & ~discard_q & ~flush;
  assign pop_empty = bus.vga_pop & fifo_empty;

  vga_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (bus.ram_rdata),
    .pop_i   (bus.vga_pop),
    .flush_i (flush),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      acc_cnt_q   <= '0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_sel_q   <= '0;
      ram_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ptr_q       <= VGA_BASE;
      discard_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;

      if (flush)     ptr_q <= VGA_BASE;
      else if (push) ptr_q <= next_ptr(ptr_q, VGA_BASE, LAST_ADDR);

      if (bus.vga_frame_start) underflow_q <= 1'b0;
      else if (pop_empty)      underflow_q <= 1'b1;

      unique case (state_q)
        ARB_IDLE: begin
          acc_cnt_q <= '0;
          discard_q <= 1'b0;
          if (grant_vga) begin
            state_q     <= ARB_VGA;
            ram_ce_q    <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= ptr_q;
            ram_sel_q   <= 4'hF;
            ram_wdata_q <= '0;
          end else if (grant_cpu) begin
            state_q     <= ARB_CPU;
            ram_ce_q    <= 1'b1;
            ram_we_q    <= bus.cpu_we;
            ram_addr_q  <= bus.cpu_addr;
            ram_sel_q   <= bus.cpu_sel;
            ram_wdata_q <= bus.cpu_wdata;
          end
        end
        ARB_CPU: begin
          if (last) begin
            state_q   <= ARB_IDLE;
            ram_ce_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            cpu_ack_q <= 1'b1;
            if (!ram_we_q) cpu_rdata_q <= bus.ram_rdata;
          end else begin
            acc_cnt_q <= acc_cnt_q + 4'd1;
          end
        end
        ARB_VGA: begin
          if (last) begin
            state_q  <= ARB_IDLE;
            ram_ce_q <= 1'b0;
          end else begin
            acc_cnt_q <= acc_cnt_q + 4'd1;
            // RAM access runs to completion; its word is dropped.
            if (flush) discard_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ARB_IDLE;
          ram_ce_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_ce        = ram_ce_q;
  assign bus.ram_we        = ram_we_q;
  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_sel       = ram_sel_q;
  assign bus.ram_wdata     = ram_wdata_q;
  assign bus.cpu_ack       = cpu_ack_q;
  assign bus.cpu_rdata     = cpu_rdata_q;
  assign bus.stallreq      = bus.cpu_req & ~cpu_ack_q;
  assign bus.vga_data      = fifo_rdata;
  assign bus.vga_empty     = fifo_empty;
  assign bus.vga_underflow = underflow_q;

`ifdef VGA_ARB_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] uflow_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      uflow_cnt_q <= '0;
    end else begin
      if (bus.stallreq && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (pop_empty && uflow_cnt_q != '1)
        uflow_cnt_q <= uflow_cnt_q + 16'd1;
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_underflows   = uflow_cnt_q;
`endif

endmodule
